frame_column_loader: RTL

Configuration frame sequencer for one fabric column. It accepts a 32-bit word stream from the bitstream source, assembles one frame's worth of per-row data on `FrameData`, then pulses the one-hot `FrameStrobe` bit of the addressed frame. That strobe is the vector which tiles such as the south terminal RAM/IO tile buffer and forward up the column.

---
 rtl/frame_loader_pkg.sv | 26 ++
 rtl/frame_strobe_gen.sv | 51 +++++
 rtl/frame_column_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// frame_loader_pkg
// Shared types and constants for the configuration frame column loader.
//   state_t   : sequencer states
//   SYNC_BYTE : required value of header bits [31:24]
//   ERR_*     : err_code encodings
// Optional feature macro used by the loader: FRAME_CHECKSUM_EN.
// ---------------------------------------------------------------------------
package frame_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      STROBE,
      HOLD
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hFA;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_SYNC  = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_CSUM  = 2'd3;

endpackage

// File: rtl/frame_strobe_gen.sv
// ---------------------------------------------------------------------------
// frame_strobe_gen
// Decodes a frame index into a one-hot strobe and holds it high for
// StrobeCycles cycles after a start pulse.
//   i_clk    : clock (rising edge)
//   i_rst    : synchronous active-high reset
//   i_start  : one-cycle start pulse; strobe rises on this edge
//   i_index  : frame index to decode (assumed < MaxFramesPerCol)
//   o_strobe : registered one-hot frame strobe
//   o_done   : high in the last strobe cycle
// ---------------------------------------------------------------------------
module frame_strobe_gen #(
   parameter int MaxFramesPerCol = 20,
   parameter int StrobeCycles    = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [7:0]                 i_index,
   output logic [MaxFramesPerCol-1:0] o_strobe,
   output logic                       o_done
);

   localparam int CNT_W = $clog2(StrobeCycles + 1);

   logic [CNT_W-1:0]           r_cnt;
   logic [MaxFramesPerCol-1:0] r_strobe;

   // r_cnt holds the number of strobe cycles still to run, including the
   // current one; the strobe is cleared on the edge that retires the last.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_strobe <= '0;
      end else if (i_start) begin
         r_cnt <= CNT_W'(StrobeCycles);
         for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
            r_strobe[i] <= (32'(i_index) == i);
         end
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
         if (r_cnt == CNT_W'(1)) begin
            r_strobe <= '0;
         end
      end
   end

   assign o_strobe = r_strobe;
   assign o_done   = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/frame_column_loader.sv
// ---------------------------------------------------------------------------
// frame_column_loader
// Configuration frame sequencer for one fabric column. Accepts a header,
// NumRows data words (and optionally a checksum word), writes them into
// FrameData in place, then pulses the one-hot FrameStrobe bit of the
// addressed frame.
//   UserCLK     : clock (rising edge)
//   Reset       : synchronous active-high reset
//   s_valid     : stream word valid
//   s_ready     : block accepts the word (transfer on s_valid & s_ready)
//   s_data      : header / data / checksum word
//   err_clr     : clears err and err_code (a new error in the same cycle wins)
//   FrameData   : row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe : one-hot frame write strobe
//   busy        : high whenever not in IDLE
//   err         : sticky error flag
//   err_code    : 1 bad sync, 2 index out of range, 3 checksum mismatch
//   frames_done : count of frames strobed (wraps)
// Macro FRAME_CHECKSUM_EN adds a CHECK state expecting the XOR of the rows.
// ---------------------------------------------------------------------------
module frame_column_loader
   import frame_loader_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 16,
   parameter int StrobeCycles    = 2
) (
   input  logic                                 UserCLK,
   input  logic                                 Reset,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [FrameBitsPerRow-1:0]           s_data,
   input  logic                                 err_clr,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic                                 err,
   output logic [1:0]                           err_code,
   output logic [15:0]                          frames_done
);

   localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

   state_t                             r_state;
   logic                               r_s_ready;
   logic                               r_busy;
   logic [ROW_W-1:0]                   r_row_cnt;
   logic [7:0]                         r_index;
   logic [NumRows*FrameBitsPerRow-1:0] r_frame_data;
   logic                               r_err;
   logic [1:0]                         r_err_code;
   logic [15:0]                        r_frames_done;
`ifdef FRAME_CHECKSUM_EN
   logic [FrameBitsPerRow-1:0]         r_csum;
   logic                               w_csum_ok;
`endif

   logic       w_acc;
   logic       w_last_row;
   logic       w_bad_sync;
   logic       w_bad_idx;
   logic       w_err_set;
   logic [1:0] w_err_code;
   logic       w_start;
   logic       w_strobe_done;

   assign w_acc      = s_valid & r_s_ready;
   assign w_last_row = (r_row_cnt == ROW_W'(NumRows - 1));
   assign w_bad_sync = (s_data[31:24] != SYNC_BYTE);
   // Full 8-bit index compared, so 20..255 are all rejected.
   assign w_bad_idx  = (32'(s_data[7:0]) >= 32'(MaxFramesPerCol));

`ifdef FRAME_CHECKSUM_EN
   assign w_csum_ok = (s_data == r_csum);
   assign w_start   = (r_state == CHECK) && w_acc && w_csum_ok;
`else
   assign w_start   = (r_state == LOAD) && w_acc && w_last_row;
`endif

   always_comb begin
      w_err_set  = 1'b0;
      w_err_code = ERR_NONE;
      if ((r_state == IDLE) && w_acc) begin
         if (w_bad_sync) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_SYNC;
         end else if (w_bad_idx) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_RANGE;
         end
      end
`ifdef FRAME_CHECKSUM_EN
      if ((r_state == CHECK) && w_acc && !w_csum_ok) begin
         w_err_set  = 1'b1;
         w_err_code = ERR_CSUM;
      end
`endif
   end

   always_ff @(posedge UserCLK) begin
      if (Reset) begin
         r_state       <= IDLE;
         r_s_ready     <= 1'b1;
         r_busy        <= 1'b0;
         r_row_cnt     <= '0;
         r_index       <= '0;
         r_frame_data  <= '0;
         r_err         <= 1'b0;
         r_err_code    <= ERR_NONE;
         r_frames_done <= '0;
`ifdef FRAME_CHECKSUM_EN
         r_csum        <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_acc && !w_err_set) begin
                  r_index   <= s_data[7:0];
                  r_row_cnt <= '0;
                  r_state   <= LOAD;
                  r_busy    <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                  r_csum    <= '0;
`endif
               end
            end
            LOAD: begin
               if (w_acc) begin
                  r_frame_data[r_row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                  r_row_cnt <= r_row_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                  r_csum    <= r_csum ^ s_data;
                  if (w_last_row) begin
                     r_state <= CHECK;
                  end
`else
                  if (w_last_row) begin
                     r_state   <= STROBE;
                     r_s_ready <= 1'b0;
                  end
`endif
               end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
               if (w_acc) begin
                  if (w_csum_ok) begin
                     r_state   <= STROBE;
                     r_s_ready <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
`endif
            STROBE: begin
               if (w_strobe_done) begin
                  r_state       <= HOLD;
                  r_frames_done <= r_frames_done + 16'd1;
               end
            end
            HOLD: begin
               r_state   <= IDLE;
               r_s_ready <= 1'b1;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_s_ready <= 1'b1;
               r_busy    <= 1'b0;
            end
         endcase

         // A new error takes priority over a simultaneous clear.
         if (w_err_set) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
         end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
         end
      end
   end

   frame_strobe_gen #(
      .MaxFramesPerCol (MaxFramesPerCol),
      .StrobeCycles    (StrobeCycles)
   ) u_strobe (
      .i_clk    (UserCLK),
      .i_rst    (Reset),
      .i_start  (w_start),
      .i_index  (r_index),
      .o_strobe (FrameStrobe),
      .o_done   (w_strobe_done)
   );

   assign s_ready     = r_s_ready;
   assign busy        = r_busy;
   assign FrameData   = r_frame_data;
   assign err         = r_err;
   assign err_code    = r_err_code;
   assign frames_done = r_frames_done;

endmodule
